rca_word_sequencer: RTL and testbench
=====================================

// Module: rca_word_sequencer
// PURPOSE
//  Multi-cycle controller that adds two WIDTH-bit operands on one shared 4-bit
//  ripple-carry slice, one nibble per clock, LSB nibble first.
//  Carry is registered between slices. The block trades latency for area in
//  wide-word paths.
//  Sits between an operand producer and a result consumer; valid/ready on both sides.
// PARAMETERS
//  WIDTH   16   operand/result width in bits; multiple of 4, >= 8
//  NCHUNK  WIDTH/4  derived slice count; localparam, not overridable
// PORTS
//  clk        in   1      single clock; all state changes on rising edge
//  rst_n      in   1      synchronous, active-low reset
//  in_valid   in   1      operand request
//  in_ready   out  1      block can accept operands
//  a          in   WIDTH  operand A, sampled on accept
//  b          in   WIDTH  operand B, sampled on accept
//  cin        in   1      carry-in, sampled on accept
//  out_valid  out  1      result available
//  out_ready  in   1      consumer takes result
//  sum        out  WIDTH  result
//  cout       out  1      carry out of the MSB slice
//  ovf        out  1      signed overflow; functional only with the macro
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0,
//    ovf=0, slice index=0. Operand/carry regs cleared. Reset aborts any operation.
//  - FSM states:
//    - IDLE: in_ready=1. in_valid=1 latches a, b, cin; idx=0; goes to RUN.
//    - RUN: in_ready=0. Each cycle computes {c,s} = a[4i+:4] + b[4i+:4] + carry
//      (full-adder equations, 5-bit result). Writes s to sum[4i+:4], carry<=c, idx++.
//      After slice NCHUNK-1, goes to DONE with cout<=c.
//    - DONE: out_valid=1, in_ready=0. sum/cout/ovf held stable until
//      out_valid&&out_ready, then goes to IDLE.
//  - Latency: accept at edge T -> out_valid=1 after edge T+NCHUNK
//    (4 cycles at WIDTH=16).
//  - Throughput: one op per NCHUNK+2 cycles minimum. No accept in the same
//    cycle as a result handoff.
//  - in_valid during RUN/DONE is ignored (in_ready=0); the producer must hold it.
//  - a/b/cin changes after accept have no effect.
//  - sum updates nibble-by-nibble during RUN. Consumers must only use sum when
//    out_valid=1.
//  - Carry wrap: result is modulo 2^WIDTH. The carry out of the MSB slice goes
//    only to cout; it never feeds back into the LSB.
//  - out_ready with out_valid=0 has no effect.
// CONFIGURATION
//  RCA_SEQ_OVF_EN defined:
//    - ovf = (a[MSB]==b[MSB]) && (sum[MSB]!=a[MSB]) for the latched operands.
//    - Registered at the RUN->DONE transition; valid with out_valid; cleared on
//      return to IDLE.
//  RCA_SEQ_OVF_EN undefined: ovf port present, tied 0, no overflow logic.
// TESTING (WIDTH=16)
//  - a=0x1234, b=0x1111, cin=0 -> sum=0x2345, cout=0; out_valid exactly 4 cycles
//    after accept.
//  - a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1 (carry ripples through all
//    4 slices). a=0xFFFF, b=0x0000, cin=1 -> same result.
//  - With RCA_SEQ_OVF_EN: a=0x7FFF, b=0x0001 -> sum=0x8000, ovf=1.
//    a=0x8000, b=0x8000 -> sum=0x0000, cout=1, ovf=1. Without the macro, ovf=0.
//  - Backpressure: hold out_ready=0 for 6 cycles after out_valid -> sum/cout
//    stable, in_ready=0. Pulse out_ready -> IDLE next cycle, in_ready=1.
//  - Toggle in_valid/a/b during RUN -> result unchanged (0x1234+0x1111=0x2345);
//    no second accept until IDLE.
//  - Drop rst_n for 1 cycle mid-RUN -> next cycle IDLE, out_valid=0, sum=0.
//    A new op 0x00FF+0x0001 then gives 0x0100.

Source files
------------

// File: rtl/rca_word_sequencer.sv
// rca_word_sequencer: adds two WIDTH-bit words over one shared 4-bit ripple slice, LSB nibble first.
// Optional signed-overflow flag enabled by defining RCA_SEQ_OVF_EN. Rev 1.0
`default_nettype none

module rca_word_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NCHUNK = WIDTH / 4;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_q, b_q;
  logic             carry;
  logic [IDXW-1:0]  idx;

  logic [3:0] sl_a, sl_b, sl_s;
  logic [4:0] cc;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // One 4-bit ripple-carry slice, shared by every nibble position.
  always_comb begin
    sl_a  = a_q[{idx, 2'b00} +: 4];
    sl_b  = b_q[{idx, 2'b00} +: 4];
    cc    = '0;
    sl_s  = '0;
    cc[0] = carry;
    for (int i = 0; i < 4; i++) begin
      sl_s[i]  = sl_a[i] ^ sl_b[i] ^ cc[i];
      cc[i+1]  = (sl_a[i] & sl_b[i]) | (cc[i] & (sl_a[i] ^ sl_b[i]));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      carry <= 1'b0;
      idx   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= b;
            carry <= cin;
            idx   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          sum[{idx, 2'b00} +: 4] <= sl_s;
          carry <= cc[4];
          idx   <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            cout  <= cc[4];
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RCA_SEQ_OVF_EN
  logic ovf_q;
  // The final sum MSB is this cycle's slice bit 3, not yet visible in sum.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (state == RUN && idx == LAST_IDX) begin
      ovf_q <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sl_s[3] != a_q[WIDTH-1]);
    end else if (state == DONE && out_ready) begin
      ovf_q <= 1'b0;
    end
  end
  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rca_word_sequencer.sv
// Randomized and directed self-checking bench for rca_word_sequencer at WIDTH=16.
`default_nettype none

module tb_rca_word_sequencer;
  localparam int W = 16;
  localparam int EXP_LAT = W / 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int total = 0;
  int bad = 0;

  rca_word_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: whole-word arithmetic, independent of slicing.
  function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic mc);
    logic [W:0] full;
    logic       mo;
    full = {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mc};
`ifdef RCA_SEQ_OVF_EN
    mo = (ma[W-1] == mb[W-1]) && (full[W-1] != ma[W-1]);
`else
    mo = 1'b0;
`endif
    return {mo, full[W], full[W-1:0]};
  endfunction

  // Accepts one operand set, scrambles the inputs afterwards, waits for the result.
  task automatic start_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic oc);
    int guard = 0;
    while (!in_ready && guard < 20) begin tick(); guard++; end
    in_valid = 1'b1; a = oa; b = ob; cin = oc;
    tick();
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin tick(); lat++; end
  endtask

  task automatic handoff();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    total++;
    if ({in_ready, out_valid, sum, cout, ovf} !== {1'b1, 1'b0, {W{1'b0}}, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset: in_ready=%b out_valid=%b sum=%h cout=%b ovf=%b, required 1 0 0000 0 0",
               in_ready, out_valid, sum, cout, ovf);
    end
  endtask

  task automatic run_and_check(input string name, input logic [W-1:0] oa,
                               input logic [W-1:0] ob, input logic oc);
    logic [W+1:0] exp;
    int lat;
    exp = model(oa, ob, oc);
    start_op(oa, ob, oc);
    wait_result(lat);
    total++;
    if (lat !== EXP_LAT) begin
      bad++;
      $display("FAIL %s latency: got %0d cycles, required %0d", name, lat, EXP_LAT);
    end
    total++;
    if ({ovf, cout, sum} !== exp) begin
      bad++;
      $display("FAIL %s result a=%h b=%h cin=%b: ovf=%b cout=%b sum=%h, required ovf=%b cout=%b sum=%h",
               name, oa, ob, oc, ovf, cout, sum, exp[W+1], exp[W], exp[W-1:0]);
    end
    handoff();
    total++;
    if ({in_ready, out_valid, ovf} !== 3'b100) begin
      bad++;
      $display("FAIL %s handoff: in_ready=%b out_valid=%b ovf=%b, required 1 0 0",
               name, in_ready, out_valid, ovf);
    end
  endtask

  task automatic test_directed();
    run_and_check("basic", 16'h1234, 16'h1111, 1'b0);
    run_and_check("ripple_b1", 16'hFFFF, 16'h0001, 1'b0);
    run_and_check("ripple_cin", 16'hFFFF, 16'h0000, 1'b1);
    run_and_check("ovf_pos", 16'h7FFF, 16'h0001, 1'b0);
    run_and_check("ovf_neg", 16'h8000, 16'h8000, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++)
      run_and_check("random", W'($urandom), W'($urandom), 1'($urandom));
  endtask

  task automatic test_backpressure();
    logic [W-1:0] s0;
    logic         c0;
    int lat;
    start_op(16'hABCD, 16'h6789, 1'b1);
    wait_result(lat);
    s0 = sum; c0 = cout;
    total++;
    if ({c0, s0} !== {1'b1, 16'h1357}) begin
      bad++;
      $display("FAIL bp_result: cout=%b sum=%h, required 1 1357", c0, s0);
    end
    in_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      total++;
      if ({out_valid, in_ready, cout, sum} !== {1'b1, 1'b0, c0, s0}) begin
        bad++;
        $display("FAIL bp_hold cycle %0d: out_valid=%b in_ready=%b cout=%b sum=%h, required 1 0 %b %h",
                 k, out_valid, in_ready, cout, sum, c0, s0);
      end
    end
    in_valid = 1'b0;
    handoff();
    total++;
    if ({in_ready, out_valid} !== 2'b10) begin
      bad++;
      $display("FAIL bp_release: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_toggle_during_run();
    int lat = 0;
    start_op(16'h1234, 16'h1111, 1'b0);
    while (!out_valid && lat < 20) begin
      total++;
      if (in_ready !== 1'b0) begin
        bad++;
        $display("FAIL toggle_in_ready cycle %0d: in_ready=%b, required 0", lat, in_ready);
      end
      in_valid = 1'($urandom); a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      tick();
      lat++;
    end
    in_valid = 1'b0;
    total++;
    if ({lat, cout, sum} !== {EXP_LAT, 1'b0, 16'h2345}) begin
      bad++;
      $display("FAIL toggle_result: lat=%0d cout=%b sum=%h, required %0d 0 2345", lat, cout, sum, EXP_LAT);
    end
    handoff();
    tick();
    total++;
    if ({in_ready, out_valid} !== 2'b10) begin
      bad++;
      $display("FAIL toggle_no_second_accept: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid_run();
    start_op(16'h5555, 16'h5555, 1'b0);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    total++;
    if ({in_ready, out_valid, sum} !== {1'b1, 1'b0, {W{1'b0}}}) begin
      bad++;
      $display("FAIL mid_reset: in_ready=%b out_valid=%b sum=%h, required 1 0 0000", in_ready, out_valid, sum);
    end
    run_and_check("after_reset", 16'h00FF, 16'h0001, 1'b0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_toggle_during_run();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, required completion");
    $fatal(1);
  end

endmodule

`default_nettype wire
